mux_sel_pipe: RTL and testbench

MUX_SEL_PIPE -- requirements
Module: mux_sel_pipe

---
 rtl/mux_sel_pipe.sv | 133 +++++++++++++
 tb/tb_mux_sel_pipe.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mux_sel_pipe.sv
//------------------------------------------------------------------------------
// Module   : mux_sel_pipe
// Brief    : Registered N:1 channel select with a two-entry skid output stage.
//            Optional error counter enabled by macro MUX_SEL_ERRCNT_EN.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_sel_pipe #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [WIDTH*NUM_IN-1:0] D,
  input  logic [SEL_W-1:0]        S,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  output logic [WIDTH-1:0]        O,
  output logic                    SEL_ERR,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [7:0]              ERR_CNT
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_err;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Out-of-range selects capture zero so downstream never sees stale channel data.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(S) == k) begin
        w_sel_data = D[k*WIDTH +: WIDTH];
      end
    end
    w_sel_err = (int'(S) >= NUM_IN);
  end

  assign IN_READY   = (state_q != ST_TWO);
  assign OUT_VALID  = (state_q != ST_EMPTY);
  assign w_in_xfer  = IN_VALID & IN_READY;
  assign w_out_xfer = OUT_VALID & OUT_READY;
  assign O          = out_data_q;
  assign SEL_ERR    = out_err_q;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    case (state_q)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          state_d    = ST_ONE;
          out_data_d = w_sel_data;
          out_err_d  = w_sel_err;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          out_data_d = w_sel_data;
          out_err_d  = w_sel_err;
        end else if (w_in_xfer) begin
          state_d     = ST_TWO;
          skid_data_d = w_sel_data;
          skid_err_d  = w_sel_err;
        end else if (w_out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_out_xfer) begin
          state_d    = ST_ONE;
          out_data_d = skid_data_q;
          out_err_d  = skid_err_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
    end
  end

`ifdef MUX_SEL_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_cnt_q <= 8'd0;
    end else if (w_in_xfer && w_sel_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign ERR_CNT = err_cnt_q;
`else
  assign ERR_CNT = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_pipe.sv
//------------------------------------------------------------------------------
// Module   : tb_mux_sel_pipe
// Brief    : Scoreboard bench for mux_sel_pipe (directed cases plus random traffic).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_sel_pipe;

  localparam int WIDTH  = 16;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 3;

  logic                    CLK = 1'b0;
  logic                    RST = 1'b1;
  logic [WIDTH*NUM_IN-1:0] D = '0;
  logic [SEL_W-1:0]        S = '0;
  logic                    IN_VALID = 1'b0;
  logic                    OUT_READY = 1'b0;
  logic                    IN_READY;
  logic [WIDTH-1:0]        O;
  logic                    SEL_ERR;
  logic                    OUT_VALID;
  logic [7:0]              ERR_CNT;

  mux_sel_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .CLK(CLK), .RST(RST), .D(D), .S(S), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .O(O), .SEL_ERR(SEL_ERR), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } entry_t;

  entry_t           sb[$];
  int               npass = 0;
  int               ntot = 0;
  int               exp_cnt = 0;
  logic [WIDTH-1:0] last_o = '0;
  logic             last_err = 1'b0;

  localparam logic [WIDTH*NUM_IN-1:0] DABC = {16'h0003, 16'h0002, 16'h0001};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic entry_t expect_of(input logic [WIDTH*NUM_IN-1:0] d,
                                       input logic [SEL_W-1:0] s);
    entry_t e;
    int     idx;
    idx = int'(s);
    if (idx < NUM_IN) begin
      e.data = d[idx*WIDTH +: WIDTH];
      e.err  = 1'b0;
    end else begin
      e.data = '0;
      e.err  = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] exp_errcnt();
`ifdef MUX_SEL_ERRCNT_EN
    return 32'(exp_cnt);
`else
    return 32'd0;
`endif
  endfunction

  // Monitor: compares the DUT against the queue of accepted entries every cycle.
  always @(negedge CLK) begin
    if (RST) begin
      sb.delete();
      exp_cnt  = 0;
      last_o   = '0;
      last_err = 1'b0;
    end else begin
      chk("in_ready", 32'(IN_READY), 32'(sb.size() < 2));
      chk("out_valid", 32'(OUT_VALID), 32'(sb.size() != 0));
      chk("err_cnt", 32'(ERR_CNT), exp_errcnt());
      if (sb.size() != 0) begin
        chk("o_head", 32'(O), 32'(sb[0].data));
        chk("sel_err_head", 32'(SEL_ERR), 32'(sb[0].err));
        if (OUT_READY) begin
          last_o   = sb[0].data;
          last_err = sb[0].err;
          void'(sb.pop_front());
        end
      end else begin
        chk("o_idle_hold", 32'(O), 32'(last_o));
        chk("sel_err_idle_hold", 32'(SEL_ERR), 32'(last_err));
      end
    end
  end

  task automatic cyc(input logic v, input logic [SEL_W-1:0] s, input logic r,
                     input logic rst_v, input logic [WIDTH*NUM_IN-1:0] d);
    entry_t e;
    @(posedge CLK);
    #1;
    RST       = rst_v;
    IN_VALID  = v;
    S         = s;
    OUT_READY = r;
    D         = d;
    @(negedge CLK);
    #1;
    if (!RST && IN_VALID && IN_READY) begin
      e = expect_of(D, S);
      sb.push_back(e);
      if (e.err && exp_cnt < 255) exp_cnt++;
    end
  endtask

  initial begin
    logic [63:0] rnd;
    cyc(0, 0, 0, 1, DABC);
    cyc(0, 0, 0, 1, DABC);
    cyc(0, 0, 0, 0, DABC);
    chk("reset_o", 32'(O), 32'h0);
    chk("reset_in_ready", 32'(IN_READY), 32'h1);

    // Single select of channel B, then a back-to-back sweep of all channels.
    cyc(1, 1, 1, 0, DABC);
    cyc(0, 0, 1, 0, DABC);
    chk("first_o", 32'(O), 32'h0002);
    for (int s = 0; s < NUM_IN; s++) cyc(1, SEL_W'(s), 1, 0, DABC);
    cyc(0, 0, 1, 0, DABC);

    // Fill both registers under backpressure, then drain.
    cyc(1, 0, 0, 0, DABC);
    cyc(1, 2, 0, 0, DABC);
    cyc(1, 1, 0, 0, DABC);
    chk("full_in_ready", 32'(IN_READY), 32'h0);
    chk("full_o_held", 32'(O), 32'h0001);
    cyc(0, 0, 1, 0, DABC);
    cyc(0, 0, 1, 0, DABC);
    cyc(0, 0, 1, 0, DABC);

    // Out-of-range selects, enough to saturate the error counter.
    for (int i = 0; i < 300; i++) cyc(1, 3, 1, 0, DABC);
    cyc(0, 0, 1, 0, DABC);
    chk("err_cnt_sat", 32'(ERR_CNT), exp_errcnt());
    chk("last_err", 32'(SEL_ERR), 32'h1);

    // Reset while full with an input offered in the reset cycle.
    cyc(1, 0, 0, 0, DABC);
    cyc(1, 1, 0, 0, DABC);
    cyc(1, 2, 0, 1, DABC);
    cyc(0, 0, 1, 0, DABC);
    chk("rst_mid_o", 32'(O), 32'h0);
    chk("rst_mid_valid", 32'(OUT_VALID), 32'h0);
    chk("rst_mid_in_ready", 32'(IN_READY), 32'h1);
    chk("rst_mid_err_cnt", 32'(ERR_CNT), 32'h0);

    for (int i = 0; i < 10000; i++) begin
      rnd = {$urandom, $urandom};
      cyc($urandom_range(0, 3) != 0, SEL_W'($urandom_range(0, 7)),
          $urandom_range(0, 2) != 0, 0, rnd[WIDTH*NUM_IN-1:0]);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, DABC);
    chk("drained", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

`default_nettype wire
